// File: rtl/npu_pkg.sv
// Shared Mini NPU types: default pixel width, signed pixel type, upsampler states.
package npu_pkg;

  localparam int DATA_WIDTH_DEFAULT = 22;

  typedef logic signed [DATA_WIDTH_DEFAULT-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROW_A = 2'd1,
    ROW_B = 2'd2,
    DONE  = 2'd3
  } ups_state_t;

endpackage

// File: rtl/upsample_2x_if.sv
// Pixel stream bundle for upsample_2x: input side and output side valid/ready pairs.
interface upsample_2x_if
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] pixel_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] pixel_out;

  modport master (
    output in_valid, pixel_in, out_ready,
    input  in_ready, out_valid, pixel_out
  );

  modport slave (
    input  in_valid, pixel_in, out_ready,
    output in_ready, out_valid, pixel_out
  );
endinterface

// File: rtl/upsample_line_buf.sv
// One-row replay buffer: single write port, asynchronous read, contents not reset.
module upsample_line_buf
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int IN_SIZE    = 15,
  localparam int AW        = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]                raddr,
  output logic signed [DATA_WIDTH-1:0] rdata
);
  logic signed [DATA_WIDTH-1:0] mem [IN_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/upsample_2x.sv
// 2x upsampler: each input pixel becomes a 2x2 block; a line buffer replays each row.
// UPSAMPLE_ZERO_INSERT_EN selects zero-insertion unpooling (no line buffer, same handshake timing).
module upsample_2x
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int IN_SIZE    = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  upsample_2x_if.slave stream,
  output logic         busy,
  output logic         done_signal
);
  localparam int AW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam logic [AW-1:0] LAST = AW'(IN_SIZE - 1);

  typedef logic signed [DATA_WIDTH-1:0] pix_t;

  ups_state_t    state, state_nx;
  logic [AW-1:0] in_x, in_x_nx, rd_x, rd_x_nx, in_y, in_y_nx, wr_idx;
  logic          vld, vld_nx, dup, dup_nx, col_last, col_last_nx, feed_done, feed_done_nx;
  pix_t          dat, dat_nx, load_val;
  logic          xfer, slot_free, final_xfer, in_rdy, accept, load_buf;

  assign xfer       = vld && stream.out_ready;
  assign slot_free  = !vld || (stream.out_ready && dup);
  // col_last marks that the register holds the row's last column, so its second
  // transfer closes the current half-row.
  assign final_xfer = xfer && dup && col_last;

`ifdef UPSAMPLE_ZERO_INSERT_EN
  assign load_val = '0;
`else
  upsample_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_SIZE    (IN_SIZE)
  ) u_line_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_idx),
    .wdata (stream.pixel_in),
    .raddr (rd_x),
    .rdata (load_val)
  );
`endif

  always_comb begin
    state_nx     = state;
    in_x_nx      = in_x;
    rd_x_nx      = rd_x;
    in_y_nx      = in_y;
    vld_nx       = vld;
    dup_nx       = dup;
    col_last_nx  = col_last;
    feed_done_nx = feed_done;
    dat_nx       = dat;
    in_rdy       = 1'b0;
    load_buf     = 1'b0;
    wr_idx       = in_x;

    if (xfer) begin
      dup_nx = !dup;
      if (dup) vld_nx = 1'b0;
    end

    case (state)
      IDLE: if (start) state_nx = ROW_A;
      ROW_A: begin
        in_rdy = slot_free && !feed_done;
        if (final_xfer) begin
          state_nx = ROW_B;
          load_buf = 1'b1;
        end
      end
      ROW_B: begin
        if (slot_free && !feed_done) load_buf = 1'b1;
        if (final_xfer) begin
          if (in_y == LAST) begin
            state_nx = DONE;
          end else begin
            // Next row's first pixel may land on this same edge to avoid a bubble.
            state_nx     = ROW_A;
            in_y_nx      = in_y + AW'(1);
            in_x_nx      = '0;
            rd_x_nx      = '0;
            feed_done_nx = 1'b0;
            wr_idx       = '0;
            in_rdy       = 1'b1;
          end
        end
      end
      DONE: begin
        state_nx     = IDLE;
        in_x_nx      = '0;
        rd_x_nx      = '0;
        in_y_nx      = '0;
        col_last_nx  = 1'b0;
        feed_done_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase

    accept = in_rdy && stream.in_valid;
    if (accept) begin
      dat_nx       = stream.pixel_in;
      vld_nx       = 1'b1;
      dup_nx       = 1'b0;
      col_last_nx  = (wr_idx == LAST);
      feed_done_nx = (wr_idx == LAST);
      if (wr_idx != LAST) in_x_nx = wr_idx + AW'(1);
    end
    if (load_buf) begin
      dat_nx       = load_val;
      vld_nx       = 1'b1;
      dup_nx       = 1'b0;
      col_last_nx  = (rd_x == LAST);
      feed_done_nx = (rd_x == LAST);
      if (rd_x != LAST) rd_x_nx = rd_x + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_x      <= '0;
      rd_x      <= '0;
      in_y      <= '0;
      vld       <= 1'b0;
      dup       <= 1'b0;
      col_last  <= 1'b0;
      feed_done <= 1'b0;
      dat       <= '0;
    end else begin
      state     <= state_nx;
      in_x      <= in_x_nx;
      rd_x      <= rd_x_nx;
      in_y      <= in_y_nx;
      vld       <= vld_nx;
      dup       <= dup_nx;
      col_last  <= col_last_nx;
      feed_done <= feed_done_nx;
      dat       <= dat_nx;
    end
  end

  assign stream.in_ready  = in_rdy;
  assign stream.out_valid = vld;
`ifdef UPSAMPLE_ZERO_INSERT_EN
  assign stream.pixel_out = dup ? '0 : dat;
`else
  assign stream.pixel_out = dat;
`endif
  assign busy        = (state != IDLE);
  assign done_signal = (state == DONE);
endmodule

// File: tb/tb_upsample_2x.sv
// Directed bench for upsample_2x with an IN_SIZE=2 and an IN_SIZE=15 instance.
module tb_upsample_2x;
  import npu_pkg::*;

  localparam int DW = DATA_WIDTH_DEFAULT;
`ifdef UPSAMPLE_ZERO_INSERT_EN
  localparam bit ZERO_MODE = 1'b1;
`else
  localparam bit ZERO_MODE = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst, start, sel, in_valid, out_ready;
  pixel_t pixel_in;
  logic   in_ready, out_valid, busy, done;
  pixel_t pixel_out;
  logic   busy2, busy15, done2, done15;

  always #5 clk = ~clk;

  upsample_2x_if #(.DATA_WIDTH(DW)) b2 ();
  upsample_2x_if #(.DATA_WIDTH(DW)) b15 ();

  upsample_2x #(.DATA_WIDTH(DW), .IN_SIZE(2)) u2 (
    .clk(clk), .rst(rst), .start(start && !sel), .stream(b2),
    .busy(busy2), .done_signal(done2));
  upsample_2x #(.DATA_WIDTH(DW), .IN_SIZE(15)) u15 (
    .clk(clk), .rst(rst), .start(start && sel), .stream(b15),
    .busy(busy15), .done_signal(done15));

  assign b2.in_valid   = in_valid && !sel;
  assign b2.pixel_in   = pixel_in;
  assign b2.out_ready  = out_ready && !sel;
  assign b15.in_valid  = in_valid && sel;
  assign b15.pixel_in  = pixel_in;
  assign b15.out_ready = out_ready && sel;
  assign in_ready      = sel ? b15.in_ready  : b2.in_ready;
  assign out_valid     = sel ? b15.out_valid : b2.out_valid;
  assign pixel_out     = sel ? b15.pixel_out : b2.pixel_out;
  assign busy          = sel ? busy15 : busy2;
  assign done          = sel ? done15 : done2;

  int     vectors = 0;
  int     miscompares = 0;
  int     n;
  pixel_t in_q[$];
  pixel_t out_q[$];
  int     first_cyc, last_cyc, done_cyc, done_cnt, busy_at_done, busy_after;
  int     stall_viol, rdy_viol;

  // Raster model: transfer k of row-group y covers two output rows of 2N each.
  function automatic pixel_t exp_pix(int k);
    int y, r, x, d;
    y = k / (4 * n);
    r = (k / (2 * n)) % 2;
    x = (k % (2 * n)) / 2;
    d = k % 2;
    if (ZERO_MODE && (r != 0 || d != 0)) return '0;
    return in_q[y * n + x];
  endfunction

  task automatic run_frame(input bit rdy_rand, input int starve_idx,
                           input int abort_at, input int start_mid);
    int idx, cyc, starve_left, pos;
    bit starved, stalled;
    pixel_t held;
    out_q.delete();
    idx = 0; cyc = 0; starve_left = 0; starved = 0; stalled = 0; held = '0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
    busy_at_done = -1; busy_after = -1; stall_viol = 0; rdy_viol = 0;
    n = sel ? 15 : 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    forever begin
      if (!starved && idx == starve_idx) begin
        starved = 1'b1;
        starve_left = 5;
      end
      start     = (cyc == start_mid);
      in_valid  = (idx < in_q.size()) && (starve_left == 0);
      pixel_in  = (idx < in_q.size()) ? in_q[idx] : '0;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled && (out_valid !== 1'b1 || pixel_out !== held)) stall_viol++;
      stalled = out_valid && !out_ready;
      held = pixel_out;
      pos = out_q.size() % (4 * n);
      if (in_ready && pos >= 2 * n && !(pos == 4 * n - 1 && out_ready)) rdy_viol++;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        out_q.push_back(pixel_out);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = int'(busy);
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = int'(busy);
        break;
      end
      if (abort_at > 0 && out_q.size() == abort_at) break;
      if (cyc > 6000) break;
      if (starve_left > 0) starve_left--;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset in_ready got %b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    vectors++; if (pixel_out !== '0) begin miscompares++; $display("FAIL reset pixel_out got %0d want 0", pixel_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset done got %b want 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int exp_tab [16];
    pixel_t got;
`ifdef UPSAMPLE_ZERO_INSERT_EN
    exp_tab = '{1, 0, 2, 0, 0, 0, 0, 0, 3, 0, 4, 0, 0, 0, 0, 0};
`else
    exp_tab = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
`endif
    sel = 1'b0;
    in_q = '{1, 2, 3, 4};
    run_frame(1'b0, -1, 0, -1);
    for (int k = 0; k < 16; k++) begin
      got = (k < out_q.size()) ? out_q[k] : 'x;
      vectors++;
      if (got !== pixel_t'(exp_tab[k])) begin
        miscompares++; $display("FAIL basic[%0d] got %0d want %0d", k, got, exp_tab[k]);
      end
    end
    vectors++; if (out_q.size() != 16) begin miscompares++; $display("FAIL basic_count got %0d want 16", out_q.size()); end
    vectors++; if (first_cyc != 1) begin miscompares++; $display("FAIL basic_latency first transfer cycle %0d want 1", first_cyc); end
    vectors++; if (last_cyc - first_cyc != 15) begin miscompares++; $display("FAIL basic_span got %0d want 15", last_cyc - first_cyc); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
    vectors++; if (done_cyc != last_cyc + 1) begin miscompares++; $display("FAIL basic_done_pos got %0d want %0d", done_cyc, last_cyc + 1); end
    vectors++; if (busy_at_done != 1) begin miscompares++; $display("FAIL basic_busy_at_done got %0d want 1", busy_at_done); end
    vectors++; if (busy_after != 0) begin miscompares++; $display("FAIL basic_busy_after got %0d want 0", busy_after); end
  endtask

  task automatic test_signed();
    pixel_t got;
    sel = 1'b0;
    in_q = '{-22'sd5, 22'sh1FFFFF, 22'sd7, -22'sh200000};
    run_frame(1'b0, -1, 0, -1);
    vectors++; if (out_q.size() != 16) begin miscompares++; $display("FAIL signed_count got %0d want 16", out_q.size()); end
    for (int k = 0; k < 16; k++) begin
      got = (k < out_q.size()) ? out_q[k] : 'x;
      vectors++;
      if (got !== exp_pix(k)) begin
        miscompares++; $display("FAIL signed[%0d] got %h want %h", k, got, exp_pix(k));
      end
    end
  endtask

  task automatic test_backpressure();
    pixel_t got;
    sel = 1'b0;
    in_q = '{10, -20, 30, -40};
    run_frame(1'b1, -1, 0, 3);
    vectors++; if (out_q.size() != 16) begin miscompares++; $display("FAIL bp_count got %0d want 16", out_q.size()); end
    for (int k = 0; k < 16; k++) begin
      got = (k < out_q.size()) ? out_q[k] : 'x;
      vectors++;
      if (got !== exp_pix(k)) begin
        miscompares++; $display("FAIL bp[%0d] got %0d want %0d", k, got, exp_pix(k));
      end
    end
    vectors++; if (stall_viol != 0) begin miscompares++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_viol); end
    vectors++; if (rdy_viol != 0) begin miscompares++; $display("FAIL bp_in_ready_row_b got %0d want 0", rdy_viol); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL bp_done_pulses got %0d want 1", done_cnt); end
    vectors++; if (done_cyc != last_cyc + 1) begin miscompares++; $display("FAIL bp_done_pos got %0d want %0d", done_cyc, last_cyc + 1); end
  endtask

  task automatic check_frame15(input string tag, input bit contiguous);
    int bad;
    bad = -1;
    for (int k = 0; k < out_q.size(); k++)
      if (bad < 0 && out_q[k] !== exp_pix(k)) bad = k;
    vectors++; if (out_q.size() != 900) begin miscompares++; $display("FAIL %s_count got %0d want 900", tag, out_q.size()); end
    vectors++;
    if (bad != -1) begin
      miscompares++; $display("FAIL %s_seq at %0d got %0d want %0d", tag, bad, out_q[bad], exp_pix(bad));
    end
    vectors++; if (rdy_viol != 0) begin miscompares++; $display("FAIL %s_in_ready_row_b got %0d want 0", tag, rdy_viol); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL %s_done_pulses got %0d want 1", tag, done_cnt); end
    if (contiguous) begin
      vectors++; if (last_cyc - first_cyc != 899) begin miscompares++; $display("FAIL %s_span got %0d want 899", tag, last_cyc - first_cyc); end
    end
  endtask

  task automatic test_starvation();
    sel = 1'b1;
    in_q.delete();
    for (int i = 0; i < 225; i++) in_q.push_back(pixel_t'(i * 3 - 300));
    run_frame(1'b0, 7, 0, -1);
    check_frame15("starve", 1'b0);
  endtask

  task automatic test_reset_mid();
    sel = 1'b1;
    in_q.delete();
    for (int i = 0; i < 225; i++) in_q.push_back(pixel_t'(i * 7 + 500));
    run_frame(1'b0, -1, 37, -1);
    vectors++; if (out_q.size() != 37) begin miscompares++; $display("FAIL rmid_reached got %0d want 37", out_q.size()); end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid out_valid got %b want 0", out_valid); end
    vectors++; if (pixel_out !== '0) begin miscompares++; $display("FAIL rmid pixel_out got %0d want 0", pixel_out); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rmid in_ready got %b want 0", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rmid done got %b want 0", done); end
    rst = 1'b0;
    in_q.delete();
    for (int i = 0; i < 225; i++) in_q.push_back(pixel_t'(1000 - i * 11));
    run_frame(1'b0, -1, 0, -1);
    check_frame15("rmid_refill", 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; pixel_in = '0;
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_starvation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
